// File: rtl/alu_issue_pkg.sv
// Shared definitions for the execute-stage issue controller: opcodes, FSM states
// and the multi-cycle opcode classifier.
package alu_issue_pkg;

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;
    localparam logic [4:0] OP_MUL = 5'b00010;
    localparam logic [4:0] OP_DIV = 5'b00011;
    localparam logic [4:0] OP_DEC = 5'b01110;
    localparam logic [4:0] OP_MAX = 5'b01110;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXEC    = 2'd1,
        WAIT_MC = 2'd2,
        DONE    = 2'd3
    } state_t;

    function automatic logic is_multicycle(input logic [4:0] opcode);
        return (opcode == OP_MUL) || (opcode == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_issue_ctrl.sv
// Execute-stage sequencer between decode and the ALU; holds operands, starts multi-cycle
// ops and hands results to writeback. Optional watchdog: define ALU_ISSUE_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | no operation held, ready for decode
// EXEC    | operands on ALU, single-cycle result or start pulse this cycle
// WAIT_MC | multiply/divide in progress, waiting for alu_valid
// DONE    | result held for writeback until wb_ready
module alu_issue_ctrl
    import alu_issue_pkg::*;
#(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned RD_W           = 5,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_opcode,
    input  logic [WIDTH-1:0] in_op1,
    input  logic [WIDTH-1:0] in_op2,
    input  logic [RD_W-1:0]  in_rd,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    output logic [4:0]       alu_opcode,
    output logic             alu_start,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_flag,
    input  logic             alu_valid,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [WIDTH-1:0] wb_result,
    output logic             wb_flag,
    output logic [RD_W-1:0]  wb_rd,
    output logic             wb_illegal,
    output logic             wb_timeout
);

    state_t           state, state_nxt;
    logic [4:0]       op_q;
    logic [WIDTH-1:0] op1_q, op2_q;
    logic [RD_W-1:0]  rd_q;
    logic [WIDTH-1:0] res_q;
    logic             flag_q;
    logic             illegal_q;

    logic accept;
    logic capture_alu;
    logic capture_illegal;
    logic capture_timeout;
    logic wd_expired;

    // A zero watchdog limit would make every multi-cycle op time out immediately.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("alu_issue_ctrl: TIMEOUT_CYCLES must be at least 1");
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        in_ready        = (state == IDLE) || ((state == DONE) && wb_ready);
        accept          = in_valid && in_ready;
        alu_start       = 1'b0;
        capture_alu     = 1'b0;
        capture_illegal = 1'b0;
        capture_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = EXEC;
            end
            EXEC: begin
                if (op_q > OP_MAX) begin
                    capture_illegal = 1'b1;
                    state_nxt       = DONE;
                end else if (is_multicycle(op_q)) begin
                    alu_start = 1'b1;
                    state_nxt = WAIT_MC;
                end else begin
                    capture_alu = 1'b1;
                    state_nxt   = DONE;
                end
            end
            WAIT_MC: begin
                if (alu_valid) begin
                    capture_alu = 1'b1;
                    state_nxt   = DONE;
                end else if (wd_expired) begin
                    capture_timeout = 1'b1;
                    state_nxt       = DONE;
                end
            end
            DONE: begin
                if (wb_ready) state_nxt = accept ? EXEC : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            op_q      <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
            rd_q      <= '0;
            res_q     <= '0;
            flag_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            if (accept) begin
                op_q  <= in_opcode;
                op1_q <= in_op1;
                op2_q <= in_op2;
                rd_q  <= in_rd;
            end
            if (capture_alu) begin
                res_q     <= alu_result;
                flag_q    <= alu_flag;
                illegal_q <= 1'b0;
            end else if (capture_illegal) begin
                res_q     <= '0;
                flag_q    <= 1'b0;
                illegal_q <= 1'b1;
            end else if (capture_timeout) begin
                res_q     <= '1;
                flag_q    <= 1'b0;
                illegal_q <= 1'b0;
            end
        end
    end

`ifdef ALU_ISSUE_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            timeout_q;

    // Loaded while in EXEC so the first WAIT_MC cycle already counts.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state == EXEC) begin
                wd_cnt <= WD_W'(TIMEOUT_CYCLES - 1);
            end else if ((state == WAIT_MC) && (wd_cnt != '0)) begin
                wd_cnt <= wd_cnt - 1'b1;
            end
            if (capture_alu || capture_illegal) begin
                timeout_q <= 1'b0;
            end else if (capture_timeout) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign wd_expired = (state == WAIT_MC) && (wd_cnt == '0);
    assign wb_timeout = timeout_q;
`else
    assign wd_expired = 1'b0;
    assign wb_timeout = 1'b0;
`endif

    assign alu_in1    = op1_q;
    assign alu_in2    = op2_q;
    assign alu_opcode = op_q;
    assign wb_valid   = (state == DONE);
    assign wb_result  = res_q;
    assign wb_flag    = flag_q;
    assign wb_rd      = rd_q;
    assign wb_illegal = illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed self-checking bench for alu_issue_ctrl with a behavioural ALU model
// (multiply/divide answer MC_LAT cycles after start).
module tb_alu_issue_ctrl;
    import alu_issue_pkg::*;

    localparam int WIDTH  = 32;
    localparam int RD_W   = 5;
    localparam int MC_LAT = 10;
    localparam logic [4:0] OP_XOR = 5'b00110;
`ifdef ALU_ISSUE_TIMEOUT_EN
    localparam int TO_CYC = 8;
`else
    localparam int TO_CYC = 64;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [4:0]       in_opcode = '0;
    logic [WIDTH-1:0] in_op1 = '0;
    logic [WIDTH-1:0] in_op2 = '0;
    logic [RD_W-1:0]  in_rd = '0;
    logic [WIDTH-1:0] alu_in1, alu_in2;
    logic [4:0]       alu_opcode;
    logic             alu_start;
    logic [WIDTH-1:0] alu_result;
    logic             alu_flag;
    logic             alu_valid;
    logic             wb_valid;
    logic             wb_ready = 1'b0;
    logic [WIDTH-1:0] wb_result;
    logic             wb_flag;
    logic [RD_W-1:0]  wb_rd;
    logic             wb_illegal;
    logic             wb_timeout;

    int checks = 0;
    int failures = 0;
    int start_cnt = 0;
    int mc_cnt = 0;
    bit mc_busy = 1'b0;
    bit mc_block = 1'b0;

    alu_issue_ctrl #(.WIDTH(WIDTH), .RD_W(RD_W), .TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_op1(in_op1), .in_op2(in_op2), .in_rd(in_rd),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_opcode(alu_opcode), .alu_start(alu_start),
        .alu_result(alu_result), .alu_flag(alu_flag), .alu_valid(alu_valid),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_result(wb_result), .wb_flag(wb_flag),
        .wb_rd(wb_rd), .wb_illegal(wb_illegal), .wb_timeout(wb_timeout)
    );

    always #5 clk = ~clk;

    always_comb begin
        alu_result = 32'hDEAD_BEEF;
        alu_flag   = 1'b1;
        if (alu_opcode <= OP_MAX) alu_flag = (alu_in1 < alu_in2);
        case (alu_opcode)
            OP_ADD: alu_result = alu_in1 + alu_in2;
            OP_SUB: alu_result = alu_in1 - alu_in2;
            OP_MUL: alu_result = alu_in1 * alu_in2;
            OP_DIV: alu_result = (alu_in2 != 0) ? alu_in1 / alu_in2 : '1;
            OP_XOR: alu_result = alu_in1 ^ alu_in2;
            OP_DEC: alu_result = alu_in1 - 1;
            default: alu_result = 32'hDEAD_BEEF;
        endcase
    end

    assign alu_valid = mc_busy && (mc_cnt == MC_LAT) && !mc_block;

    always @(posedge clk) begin
        if (alu_start === 1'b1) start_cnt <= start_cnt + 1;
        if (!rst) begin
            mc_busy <= 1'b0;
            mc_cnt  <= 0;
        end else if (alu_start) begin
            mc_busy <= 1'b1;
            mc_cnt  <= 1;
        end else if (mc_busy) begin
            if (alu_valid) mc_busy <= 1'b0;
            else if (mc_cnt < MC_LAT) mc_cnt <= mc_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        in_valid  = 1'b1;
        in_opcode = op;
        in_op1    = a;
        in_op2    = b;
        in_rd     = rd;
    endtask

    initial begin
        int s0;
        int waited;
        bit stable;
        bit blocked;

        tick();
        tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_alu_start", alu_start, 0);
        check("rst_wb_result", wb_result, 0);
        check("rst_wb_rd", wb_rd, 0);
        check("rst_alu_in1", alu_in1, 0);
        check("rst_wb_illegal", wb_illegal, 0);
        check("rst_wb_timeout", wb_timeout, 0);
        rst = 1'b1;
        tick();

        // add 5+7 -> 12, rd 3
        s0 = start_cnt;
        wb_ready = 1'b1;
        issue(OP_ADD, 5, 7, 3);
        #1;
        check("add_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("add_exec_wb_valid", wb_valid, 0);
        check("add_exec_alu_in1", alu_in1, 5);
        check("add_exec_alu_in2", alu_in2, 7);
        tick();
        check("add_wb_valid", wb_valid, 1);
        check("add_wb_result", wb_result, 12);
        check("add_wb_rd", wb_rd, 3);
        check("add_wb_flag", wb_flag, 1);
        tick();
        check("add_retired", wb_valid, 0);
        check("add_no_start", start_cnt - s0, 0);

        // multiply 6*7 -> 42
        s0 = start_cnt;
        issue(OP_MUL, 6, 7, 5);
        tick();
        in_valid = 1'b0;
        check("mul_start_exec", alu_start, 1);
        tick();
        check("mul_start_cleared", alu_start, 0);
        waited = 0;
        stable = 1'b1;
        while (wb_valid !== 1'b1 && waited < 30) begin
            stable &= (alu_in1 === 6) && (alu_in2 === 7) && (alu_opcode === OP_MUL)
                      && (alu_start === 1'b0);
            tick();
            waited++;
        end
        check("mul_wait_cycles", waited, MC_LAT);
        check("mul_inputs_stable", stable, 1);
        check("mul_wb_result", wb_result, 42);
        check("mul_wb_rd", wb_rd, 5);
        check("mul_single_start", start_cnt - s0, 1);
        tick();
        check("mul_retired", wb_valid, 0);

        // sub 10-4 under back-pressure, then xor issued on the retiring edge
        wb_ready = 1'b0;
        issue(OP_SUB, 10, 4, 7);
        tick();
        issue(OP_XOR, 32'hF0, 32'hFF, 9);
        tick();
        check("sub_wb_valid", wb_valid, 1);
        check("sub_wb_result", wb_result, 6);
        check("sub_wb_flag", wb_flag, 0);
        blocked = 1'b1;
        for (int i = 0; i < 5; i++) begin
            blocked &= (in_ready === 1'b0) && (wb_valid === 1'b1) && (wb_result === 6)
                       && (wb_rd === 7);
            tick();
        end
        check("bp_held", blocked, 1);
        check("bp_in_ready", in_ready, 0);
        wb_ready = 1'b1;
        #1;
        check("b2b_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("b2b_exec_wb_valid", wb_valid, 0);
        check("b2b_alu_in1", alu_in1, 32'hF0);
        check("b2b_alu_opcode", alu_opcode, OP_XOR);
        tick();
        check("xor_wb_valid", wb_valid, 1);
        check("xor_wb_result", wb_result, 32'h0F);
        check("xor_wb_rd", wb_rd, 9);
        tick();
        check("xor_retired", wb_valid, 0);

        // illegal opcode 11111
        s0 = start_cnt;
        issue(5'b11111, 3, 4, 2);
        tick();
        in_valid = 1'b0;
        check("ill_no_start_exec", alu_start, 0);
        tick();
        check("ill_wb_valid", wb_valid, 1);
        check("ill_wb_illegal", wb_illegal, 1);
        check("ill_wb_result", wb_result, 0);
        check("ill_wb_flag", wb_flag, 0);
        check("ill_no_start", start_cnt - s0, 0);
        tick();

        // dec at the top legal opcode clears the illegal marker
        issue(OP_DEC, 9, 0, 1);
        tick();
        in_valid = 1'b0;
        tick();
        check("dec_wb_valid", wb_valid, 1);
        check("dec_wb_result", wb_result, 8);
        check("dec_wb_illegal", wb_illegal, 0);
        tick();

        // reset during WAIT_MC of a divide
        mc_block = 1'b1;
        issue(OP_DIV, 100, 7, 4);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        check("rdiv_waiting_in_ready", in_ready, 0);
        check("rdiv_waiting_wb_valid", wb_valid, 0);
        rst = 1'b0;
        tick();
        check("rdiv_wb_valid", wb_valid, 0);
        check("rdiv_alu_start", alu_start, 0);
        check("rdiv_in_ready", in_ready, 1);
        check("rdiv_alu_in1", alu_in1, 0);
        rst = 1'b1;
        mc_block = 1'b0;
        tick();

        // full divide 100/7 -> 14
        issue(OP_DIV, 100, 7, 4);
        tick();
        in_valid = 1'b0;
        tick();
        waited = 0;
        while (wb_valid !== 1'b1 && waited < 30) begin
            tick();
            waited++;
        end
        check("div_wait_cycles", waited, MC_LAT);
        check("div_wb_result", wb_result, 14);
        check("div_wb_timeout", wb_timeout, 0);
        tick();

        // divide whose ALU never answers
        mc_block = 1'b1;
        issue(OP_DIV, 50, 5, 6);
        tick();
        in_valid = 1'b0;
        tick();
        waited = 0;
        while (wb_valid !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
`ifdef ALU_ISSUE_TIMEOUT_EN
        check("to_wait_cycles", waited, TO_CYC);
        check("to_wb_timeout", wb_timeout, 1);
        check("to_wb_result", wb_result, 32'hFFFF_FFFF);
        check("to_wb_rd", wb_rd, 6);
`else
        check("hang_wait_cycles", waited, 20);
        check("hang_wb_valid", wb_valid, 0);
        check("hang_wb_timeout", wb_timeout, 0);
        check("hang_in_ready", in_ready, 0);
`endif
        mc_block = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
